// File: rtl/ysyx_24100012_wbu_pkg.sv
// Shared constants for the write-back unit: index width default, load funct3
// encodings and the reset values of the register file write port.
package ysyx_24100012_wbu_pkg;
    localparam int IDX_W_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic        RST_WEN   = 1'b0;
    localparam int unsigned RST_INDEX = 0;
    localparam int unsigned RST_DATA  = 0;
endpackage

// File: rtl/ysyx_24100012_load_fmt.sv
// Load data formatter: picks the byte/half lane out of an aligned memory word
// and sign/zero extends it; unknown funct3 falls through as a word load.
module ysyx_24100012_load_fmt
    import ysyx_24100012_wbu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    output logic [WIDTH-1:0] data,
    output logic             illegal
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(WIDTH-16){half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {{(WIDTH-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(WIDTH-16){1'b0}}, half_sel};
            default: begin
                data    = rdata;
                illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/ysyx_24100012_wbu.sv
// Write-back unit: arbitrates ALU/LSU results (LSU first), registers one
// register file write per cycle and tracks per-register busy bits for decode.
module ysyx_24100012_wbu
    import ysyx_24100012_wbu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REG = 32,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [IDX_W-1:0] issue_rs1,
    input  logic [IDX_W-1:0] issue_rs2,
    input  logic             issue_rs1_en,
    input  logic             issue_rs2_en,
    input  logic             issue_rd_en,
    input  logic [IDX_W-1:0] issue_rd,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [IDX_W-1:0] alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [IDX_W-1:0] lsu_rd,
    input  logic [WIDTH-1:0] lsu_rdata,
    input  logic [2:0]       lsu_funct3,
    input  logic [1:0]       lsu_addr_lo,
    output logic             RegWEn,
    output logic [IDX_W-1:0] RegWriteIndex,
    output logic [WIDTH-1:0] RegWriteData,
    output logic             wb_err
);
    localparam int NB = 2**IDX_W;

    // Busy bits span the whole index space; indices >= N_REG are never set,
    // so they always read as free and an out-of-range result flags an error.
    logic [NB-1:0]    busy, busy_nxt, in_range;
    logic [WIDTH-1:0] fmt_data, sel_data;
    logic [IDX_W-1:0] sel_rd;
    logic             fmt_illegal, acc_lsu, acc_alu, acc, wr_ok, err_now, issue_fire;

    for (genvar i = 0; i < NB; i++) begin : g_range
        assign in_range[i] = (i < N_REG) ? 1'b1 : 1'b0;
    end

    ysyx_24100012_load_fmt #(.WIDTH(WIDTH)) u_load_fmt (
        .rdata   (lsu_rdata),
        .funct3  (lsu_funct3),
        .addr_lo (lsu_addr_lo),
        .data    (fmt_data),
        .illegal (fmt_illegal)
    );

    assign issue_ready = !((issue_rs1_en && busy[issue_rs1]) ||
                           (issue_rs2_en && busy[issue_rs2]) ||
                           (issue_rd_en  && busy[issue_rd]));
    assign issue_fire  = issue_valid && issue_ready && issue_rd_en &&
                         (issue_rd != '0) && in_range[issue_rd];

    assign lsu_ready = 1'b1;
    assign alu_ready = !lsu_valid;
    assign acc_lsu   = lsu_valid;
    assign acc_alu   = alu_valid && !lsu_valid;
    assign acc       = acc_lsu || acc_alu;
    assign sel_rd    = acc_lsu ? lsu_rd : alu_rd;
    assign sel_data  = acc_lsu ? fmt_data : alu_data;
    assign wr_ok     = (sel_rd != '0) && in_range[sel_rd];
    assign err_now   = acc && (((sel_rd != '0) && !busy[sel_rd]) ||
                               (acc_lsu && fmt_illegal));

    // Set after clear so a forced same-index set/clear keeps the bit set.
    always_comb begin
        busy_nxt = busy;
        if (RegWEn)
            busy_nxt[RegWriteIndex] = 1'b0;
        if (issue_fire)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWEn        <= RST_WEN;
            RegWriteIndex <= IDX_W'(RST_INDEX);
            RegWriteData  <= WIDTH'(RST_DATA);
            wb_err        <= 1'b0;
            busy          <= '0;
        end else begin
            RegWEn <= acc && wr_ok;
            if (acc) begin
                RegWriteIndex <= sel_rd;
                RegWriteData  <= sel_data;
            end
            if (err_now)
                wb_err <= 1'b1;
            busy <= busy_nxt;
        end
    end
endmodule

// File: doc/ysyx_24100012_wbu.md
Name: ysyx_24100012_wbu

Overview:
- Write-back unit: the writer side of the integer register file.
- Accepts results from the ALU and the LSU over valid/ready, formats load data, and drives the register file write port through a registered stage.
- Keeps a per-register busy scoreboard. The decode stage queries it to stall on RAW/WAW hazards.
- Sits between EXU/LSU and the register file.

Parameters:
WIDTH, 32, data width; load formatting is defined for 32 only
N_REG, 32, number of architectural registers (16 for RV32E)
IDX_W, 5, register index width, 2**IDX_W >= N_REG

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
issue_valid  in  1  decode presents an instruction
issue_ready  out  1  instruction may issue (no hazard)
issue_rs1  in  IDX_W  source 1 index
issue_rs2  in  IDX_W  source 2 index
issue_rs1_en  in  1  rs1 is read
issue_rs2_en  in  1  rs2 is read
issue_rd_en  in  1  instruction writes rd
issue_rd  in  IDX_W  destination index
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted
alu_rd  in  IDX_W  ALU destination
alu_data  in  WIDTH  ALU result
lsu_valid  in  1  load result valid
lsu_ready  out  1  load result accepted
lsu_rd  in  IDX_W  load destination
lsu_rdata  in  WIDTH  raw aligned memory word
lsu_funct3  in  3  load type
lsu_addr_lo  in  2  byte offset of access
RegWEn  out  1  register file write enable
RegWriteIndex  out  IDX_W  write index
RegWriteData  out  WIDTH  write data
wb_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1):
  - RegWEn=0, RegWriteIndex=0, RegWriteData=0, wb_err=0.
  - All busy bits cleared.
  - In-flight accepted results are discarded.
  - After reset deasserts, first acceptance is possible on the first clock edge.
- Arbitration:
  - lsu_ready=1 always.
  - alu_ready=!lsu_valid, so the LSU has fixed priority.
  - A handshake occurs when valid && ready at a rising edge.
  - Producers must hold valid/rd/data stable until accepted.
- Output stage: a handshake at edge T registers the result. RegWEn=1 with index/data during cycle T..T+1, so the regfile commits at edge T+1. With no handshake, RegWEn=0 the next cycle; index/data hold their previous values. Latency is 1 cycle from acceptance to RegWEn.
- x0: a result with rd==0 is accepted and consumed but drives RegWEn=0. busy[0] is never set.
- Load formatting uses byte lane = lsu_addr_lo, half lane = lsu_addr_lo[1]:
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend selected half.
  - 010 LW: word.
  - 100 LBU: zero-extend selected byte.
  - 101 LHU: zero-extend selected half.
  - Any other encoding: treated as LW and sets wb_err.
- Scoreboard (busy[N_REG-1:1]):
  - Set at an edge where issue_valid && issue_ready && issue_rd_en && issue_rd!=0.
  - Cleared at an edge where RegWEn=1, clearing busy[RegWriteIndex]. A reader issuing after the clear reads the committed value.
- Hazard (combinational): issue_ready = !( (issue_rs1_en && busy[rs1]) || (issue_rs2_en && busy[rs2]) || (issue_rd_en && busy[rd]) ). Index 0 is never busy.
- Simultaneous set and clear of the same index cannot occur, because busy[rd] blocks issue. If it is forced anyway, set wins.
- At most one pending writer per register (WAW blocked).
- wb_err is set (sticky until reset) when either:
  - a result is accepted with rd!=0 whose busy bit is clear; or
  - an illegal lsu_funct3 is accepted.
- Index >= N_REG: write is suppressed and wb_err is set.

Decomposition:
- Shared package:
  - IDX_W default.
  - Load funct3 constants (LB, LH, LW, LBU, LHU).
  - Reset values of the write port.
- One sub-module: ysyx_24100012_load_fmt, combinational (rdata, funct3, addr_lo) -> (data, illegal).
- Arbiter, output register and scoreboard stay in the top.

Test Plan:
- Issue rd=5, then ALU result rd=5 data 0x1234 -> busy[5]=1 and issue_ready=0 for rs1=5. The cycle after acceptance: RegWEn=1, index 5, data 0x1234. The next cycle: busy[5]=0, issue_ready=1.
- lsu_rdata=0x80FF7F01 with:
  - LB, addr_lo=3 -> 0xFFFFFF80.
  - LBU, addr_lo=1 -> 0x0000007F.
  - LH, addr_lo=2 -> 0xFFFF80FF.
  - LHU, addr_lo=0 -> 0x00007F01.
- ALU rd=3 and LSU rd=4 valid in the same cycle -> lsu_ready=1, alu_ready=0. Writes land in order: index 4 then index 3, in consecutive cycles.
- ALU result rd=0 data 0xDEAD -> alu_ready=1, RegWEn stays 0, wb_err stays 0.
- ALU result rd=7 with busy[7]=0 -> wb_err=1 and stays 1. lsu_funct3=011 -> wb_err=1, data passed as LW.
- Assert rst mid-cycle with busy[2]=1 and RegWEn=1 -> immediately RegWEn=0, busy cleared, issue_ready=1 for any indices.
